prdt_resolve: RTL and testbench

Branch-prediction resolution unit at the execute end of the static fetch-side predictor. It buffers each prediction made at fetch in a small in-order queue. When execute resolves the same control-flow instruction, the unit compares the actual outcome against the queued prediction and raises a one-cycle flush with the corrected fetch address on a mispredict. It also keeps branch and mispredict counters for performance CSRs.

---
 rtl/prdt_resolve.sv | 110 +++++++++++
 tb/tb_prdt_resolve.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prdt_resolve.sv
// Branch-prediction resolution: in-order queue of fetch-side predictions checked
// against execute outcomes, with one-cycle mispredict flush/redirect and perf counters.
module prdt_resolve #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid_i,
  input  logic        push_taken_i,
  input  logic [31:0] push_addr_i,
  input  logic [31:0] push_pc_i,
  output logic        full_o,
  input  logic        resolve_valid_i,
  input  logic        resolve_taken_i,
  input  logic [31:0] resolve_addr_i,
  input  logic        flush_i,
  output logic        flush_o,
  output logic [31:0] redirect_addr_o,
  output logic        overflow_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic          taken_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          empty, full, pop, mispredict, push_ok, ovf_set;
  logic          h_taken;
  logic [31:0]   h_addr, h_pc, redirect_nxt;
  logic [AW:0]   rd_ptr_inc;

  logic          vld_p1;
  logic [31:0]   redirect_p1;
  logic          overflow_q;
  logic [31:0]   branch_cnt_q, mispredict_cnt_q;

  // Fall-through fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Stage p0: head compare and push/pop decisions
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    h_taken      = taken_mem[rd_ptr[AW-1:0]];
    h_addr       = addr_mem[rd_ptr[AW-1:0]];
    h_pc         = pc_mem[rd_ptr[AW-1:0]];
    rd_ptr_inc   = rd_ptr + PTR_ONE;
    pop          = resolve_valid_i && !empty && !flush_i;
    mispredict   = pop && ((resolve_taken_i != h_taken) ||
                           (resolve_taken_i && h_taken && (resolve_addr_i != h_addr)));
    // A push alongside a mispredict is wrong-path: dropped without flagging overflow.
    push_ok      = push_valid_i && (!full || pop) && !mispredict && !flush_i;
    ovf_set      = push_valid_i && full && !pop && !flush_i;
    redirect_nxt = resolve_taken_i ? resolve_addr_i : seq_pc(h_pc);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      taken_mem[wr_ptr[AW-1:0]] <= push_taken_i;
      addr_mem[wr_ptr[AW-1:0]]  <= push_addr_i;
      pc_mem[wr_ptr[AW-1:0]]    <= push_pc_i;
    end
  end

  // Stage p1: registered pointers, flush pulse, redirect and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      vld_p1           <= 1'b0;
      redirect_p1      <= 32'h0;
      overflow_q       <= 1'b0;
      branch_cnt_q     <= 32'h0;
      mispredict_cnt_q <= 32'h0;
    end else begin
      vld_p1 <= mispredict;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (mispredict) begin
        rd_ptr <= rd_ptr_inc;
        wr_ptr <= rd_ptr_inc;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr_inc;
      end
      if (mispredict) begin
        redirect_p1      <= redirect_nxt;
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
      if (pop)     branch_cnt_q <= branch_cnt_q + 32'd1;
      if (ovf_set) overflow_q   <= 1'b1;
    end
  end

  assign full_o           = full;
  assign flush_o          = vld_p1;
  assign redirect_addr_o  = redirect_p1;
  assign overflow_o       = overflow_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_prdt_resolve.sv
// Scoreboard bench for prdt_resolve: a queue-based reference model predicts every
// post-edge output; a monitor compares them each cycle.
module tb_prdt_resolve;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        push_valid_i = 1'b0, push_taken_i = 1'b0;
  logic [31:0] push_addr_i = '0, push_pc_i = '0;
  logic        full_o;
  logic        resolve_valid_i = 1'b0, resolve_taken_i = 1'b0;
  logic [31:0] resolve_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        flush_o;
  logic [31:0] redirect_addr_o;
  logic        overflow_o;
  logic [31:0] branch_cnt_o, mispredict_cnt_o;

  prdt_resolve #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid_i(push_valid_i), .push_taken_i(push_taken_i),
    .push_addr_i(push_addr_i), .push_pc_i(push_pc_i),
    .full_o(full_o),
    .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
    .resolve_addr_i(resolve_addr_i),
    .flush_i(flush_i), .flush_o(flush_o), .redirect_addr_o(redirect_addr_o),
    .overflow_o(overflow_o), .branch_cnt_o(branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] addr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        flush;
    logic [31:0] redir;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
    logic        full;
    logic        ovf;
  } exp_t;

  ent_t        mq[$];
  exp_t        sb[$];
  logic [31:0] m_bcnt = '0, m_mcnt = '0, m_redir = '0;
  logic        m_ovf = 1'b0;
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_bcnt = '0; m_mcnt = '0; m_redir = '0; m_ovf = 1'b0;
  endtask

  // Reference: a plain list of outstanding predictions, updated per the resolution rules.
  task automatic model_step(input logic pv, input logic pt, input logic [31:0] pa,
                            input logic [31:0] pp, input logic rv, input logic rt,
                            input logic [31:0] ra, input logic fl);
    exp_t e;
    ent_t h, n;
    int   sz;
    logic pop, mis;
    e.flush = 1'b0;
    sz = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      pop = rv && (sz > 0);
      mis = 1'b0;
      if (pop) begin
        h = mq[0];
        mis = (rt != h.taken) || (rt && h.taken && ra != h.addr);
        m_bcnt++;
        if (mis) begin
          m_mcnt++;
          m_redir = rt ? ra : h.pc + 32'd4;
          e.flush = 1'b1;
        end
      end
      if (mis) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (pv) begin
          if (sz < DEPTH || pop) begin
            n.taken = pt; n.addr = pa; n.pc = pp;
            mq.push_back(n);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    e.redir = m_redir; e.bcnt = m_bcnt; e.mcnt = m_mcnt;
    e.full = (mq.size() == DEPTH); e.ovf = m_ovf;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic pv, input logic pt, input logic [31:0] pa,
                     input logic [31:0] pp, input logic rv, input logic rt,
                     input logic [31:0] ra, input logic fl);
    @(negedge clk);
    push_valid_i = pv; push_taken_i = pt; push_addr_i = pa; push_pc_i = pp;
    resolve_valid_i = rv; resolve_taken_i = rt; resolve_addr_i = ra; flush_i = fl;
    model_step(pv, pt, pa, pp, rv, rt, ra, fl);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic push(input logic pt, input logic [31:0] pa, input logic [31:0] pp);
    cyc(1'b1, pt, pa, pp, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] ra);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, rt, ra, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle the DUT presents a new output set, compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("flush_o",          {31'h0, flush_o},    {31'h0, e.flush});
        chk("redirect_addr_o",  redirect_addr_o,     e.redir);
        chk("branch_cnt_o",     branch_cnt_o,        e.bcnt);
        chk("mispredict_cnt_o", mispredict_cnt_o,    e.mcnt);
        chk("full_o",           {31'h0, full_o},     {31'h0, e.full});
        chk("overflow_o",       {31'h0, overflow_o}, {31'h0, e.ovf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] saved_b, saved_m;
    int          waited;
    #1 rst_n = 1'b0;
    #2;
    chk("reset flush_o",   {31'h0, flush_o},    32'h0);
    chk("reset redirect",  redirect_addr_o,     32'h0);
    chk("reset full_o",    {31'h0, full_o},     32'h0);
    chk("reset overflow",  {31'h0, overflow_o}, 32'h0);
    chk("reset bcnt",      branch_cnt_o,        32'h0);
    chk("reset mcnt",      mispredict_cnt_o,    32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Correct prediction
    push(1'b1, 32'h80, 32'h100);
    resolve(1'b1, 32'h80);
    after_edge();
    chk("t1 flush", {31'h0, flush_o}, 32'h0);
    chk("t1 bcnt", branch_cnt_o, 32'd1);
    chk("t1 mcnt", mispredict_cnt_o, 32'd0);

    // Direction mispredict, fall-through redirect
    push(1'b1, 32'h80, 32'h100);
    resolve(1'b0, 32'h0);
    after_edge();
    chk("t2 flush", {31'h0, flush_o}, 32'h1);
    chk("t2 redirect", redirect_addr_o, 32'h104);
    chk("t2 mcnt", mispredict_cnt_o, 32'd1);
    idle();
    after_edge();
    chk("t2 flush pulse", {31'h0, flush_o}, 32'h0);

    // Not-taken predicted, taken actual; then target mismatch
    push(1'b0, 32'h0, 32'h200);
    resolve(1'b1, 32'h300);
    after_edge();
    chk("t3 redirect taken", redirect_addr_o, 32'h300);
    push(1'b1, 32'h40, 32'h210);
    resolve(1'b1, 32'h44);
    after_edge();
    chk("t3 target flush", {31'h0, flush_o}, 32'h1);
    chk("t3 target redirect", redirect_addr_o, 32'h44);

    // Fill, overflow, push-with-pop while full
    for (int i = 0; i < DEPTH; i++) push(1'b1, 32'h80, 32'h1000 + 32'(i * 4));
    after_edge();
    chk("t4 full", {31'h0, full_o}, 32'h1);
    push(1'b1, 32'h80, 32'h2000);
    after_edge();
    chk("t4 overflow", {31'h0, overflow_o}, 32'h1);
    cyc(1'b1, 1'b1, 32'h80, 32'h3000, 1'b1, 1'b1, 32'h80, 1'b0);
    after_edge();
    chk("t4 full after push+pop", {31'h0, full_o}, 32'h1);
    chk("t4 no flush", {31'h0, flush_o}, 32'h0);
    for (int i = 0; i < DEPTH; i++) resolve(1'b1, 32'h80);

    // Mispredict with simultaneous push, then an ignored resolve
    for (int i = 0; i < 3; i++) push(1'b1, 32'h80, 32'h4000 + 32'(i * 4));
    cyc(1'b1, 1'b1, 32'h80, 32'h5000, 1'b1, 1'b0, 32'h0, 1'b0);
    resolve(1'b1, 32'h80);
    after_edge();
    saved_b = m_bcnt;
    chk("t5 ignored resolve bcnt", branch_cnt_o, saved_b);
    chk("t5 queue empty", {31'h0, full_o}, 32'h0);

    // PC wrap, and flush_i overriding a mispredict
    push(1'b1, 32'h80, 32'hFFFF_FFFC);
    resolve(1'b0, 32'h0);
    after_edge();
    chk("t6 wrap redirect", redirect_addr_o, 32'h0);
    push(1'b1, 32'h80, 32'h500);
    saved_b = m_bcnt; saved_m = m_mcnt;
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    after_edge();
    chk("t6 flush_i no flush_o", {31'h0, flush_o}, 32'h0);
    chk("t6 flush_i bcnt", branch_cnt_o, saved_b);
    chk("t6 flush_i mcnt", mispredict_cnt_o, saved_m);
    resolve(1'b0, 32'h0);
    after_edge();
    chk("t6 empty after flush_i", branch_cnt_o, saved_b);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 3)) << 4, $urandom,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
          32'($urandom_range(0, 3)) << 4, 1'($urandom_range(0, 40) == 0));
    end
    idle();

    // Asynchronous reset mid-operation
    for (int i = 0; i < 10; i++) push(1'b1, 32'h80, 32'h6000);
    resolve(1'b0, 32'h0);
    idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst flush_o",  {31'h0, flush_o},    32'h0);
    chk("async rst redirect", redirect_addr_o,     32'h0);
    chk("async rst full_o",   {31'h0, full_o},     32'h0);
    chk("async rst overflow", {31'h0, overflow_o}, 32'h0);
    chk("async rst bcnt",     branch_cnt_o,        32'h0);
    chk("async rst mcnt",     mispredict_cnt_o,    32'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 1)) << 4, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 1)) << 4, 1'b0);
    end
    idle();

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
